// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
// Shared types and constants for the stopwatch control block.
//   state_t    : FSM state encoding (RUN, PAUSE, ADJ)
//   bcd_t      : one BCD digit
//   SEC_LIMIT  : highest seconds value before wrap
//   BLK_*      : bit positions of each digit in the blank vector
//   blank_mask : blank pattern for the field being adjusted
package stopwatch_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PAUSE = 2'd1,
        ADJ   = 2'd2
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam int SEC_LIMIT = 59;

    localparam int BLK_MIN_TENS = 3;
    localparam int BLK_MIN_ONES = 2;
    localparam int BLK_SEC_TENS = 1;
    localparam int BLK_SEC_ONES = 0;

    // sel = 0 selects minutes, sel = 1 selects seconds.
    function automatic logic [3:0] blank_mask(input logic sel);
        logic [3:0] m;
        m = 4'b0000;
        if (sel) begin
            m[BLK_SEC_TENS] = 1'b1;
            m[BLK_SEC_ONES] = 1'b1;
        end else begin
            m[BLK_MIN_TENS] = 1'b1;
            m[BLK_MIN_ONES] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter
// Two-digit BCD counter that counts 00..LIMIT and wraps to 00.
// Ports:
//   src_clk : clock
//   reset   : synchronous active-high reset, clears to 00
//   inc     : advance by one this cycle
//   clr     : clear to 00 (wins over inc)
//   tens    : BCD tens digit (registered)
//   ones    : BCD ones digit (registered)
//   wrap    : combinational, high when inc is applied at LIMIT
module bcd_mod_counter
    import stopwatch_pkg::*;
#(
    parameter int LIMIT = 59
) (
    input  logic src_clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output bcd_t tens,
    output bcd_t ones,
    output logic wrap
);

    localparam bcd_t LIM_TENS = bcd_t'(LIMIT / 10);
    localparam bcd_t LIM_ONES = bcd_t'(LIMIT % 10);

    logic at_limit;

    assign at_limit = (tens == LIM_TENS) && (ones == LIM_ONES);
    assign wrap     = inc & at_limit;

    always_ff @(posedge src_clk) begin
        if (reset || clr) begin
            tens <= 4'd0;
            ones <= 4'd0;
        end else if (inc) begin
            if (at_limit) begin
                tens <= 4'd0;
                ones <= 4'd0;
            end else if (ones == 4'd9) begin
                tens <= tens + 4'd1;
                ones <= 4'd0;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
// Control FSM and MM:SS BCD time datapath for the stopwatch.
// Rising edges of the divider square waves become one-cycle ticks; the FSM
// sequences RUN / PAUSE / ADJ and the counters advance on tick_1 (RUN) or
// tick_2 (ADJ, selected field only).
// Optional feature macro: STOPWATCH_LAP_EN (lap freeze of the displayed time).
// Ports:
//   src_clk, reset                 : clock, synchronous active-high reset
//   clk_1hz, clk_2hz, clk_4hz      : divider square waves sampled as data
//   btn_pause, btn_rst, btn_lap    : debounced one-cycle button pulses
//   sw_adj, sw_sel                 : adjust mode level, field select level
//   min_tens..sec_ones             : BCD digits to the display mux
//   blank                          : per-digit blank {mt, mo, st, so}
//   running                        : high while in RUN
//   rollover                       : one-cycle pulse on MIN_LIMIT:59 -> 00:00
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int MIN_LIMIT    = 59,
    parameter int START_PAUSED = 1
) (
    input  logic       src_clk,
    input  logic       reset,
    input  logic       clk_1hz,
    input  logic       clk_2hz,
    input  logic       clk_4hz,
    input  logic       btn_pause,
    input  logic       btn_rst,
    input  logic       btn_lap,
    input  logic       sw_adj,
    input  logic       sw_sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] blank,
    output logic       running,
    output logic       rollover
);

    localparam state_t INIT_STATE = (START_PAUSED != 0) ? PAUSE : RUN;

    state_t state;
    logic   clk_1hz_d;
    logic   clk_2hz_d;
    logic   tick_1;
    logic   tick_2;
    logic   in_run;
    logic   in_adj;
    logic   sec_inc;
    logic   min_inc;
    logic   sec_wrap;
    logic   min_wrap;
    bcd_t   live_min_tens;
    bcd_t   live_min_ones;
    bcd_t   live_sec_tens;
    bcd_t   live_sec_ones;

    // Edge detection: previous-cycle samples of the square waves
    always_ff @(posedge src_clk) begin
        if (reset) begin
            clk_1hz_d <= 1'b0;
            clk_2hz_d <= 1'b0;
        end else begin
            clk_1hz_d <= clk_1hz;
            clk_2hz_d <= clk_2hz;
        end
    end

    assign tick_1 = clk_1hz & ~clk_1hz_d;
    assign tick_2 = clk_2hz & ~clk_2hz_d;
    assign in_run = (state == RUN);
    assign in_adj = (state == ADJ);

    // btn_rst suppresses every increment, which also keeps the wrap (and so
    // rollover) low in a cycle where a clear coincides with a wrap.
    // Seconds only carry into minutes in RUN; in ADJ the fields are independent.
    assign sec_inc = ~btn_rst & ((in_run & tick_1) | (in_adj & tick_2 & sw_sel));
    assign min_inc = ~btn_rst & ((in_run & sec_wrap) | (in_adj & tick_2 & ~sw_sel));

    bcd_mod_counter #(.LIMIT(SEC_LIMIT)) u_sec (
        .src_clk (src_clk),
        .reset   (reset),
        .inc     (sec_inc),
        .clr     (btn_rst),
        .tens    (live_sec_tens),
        .ones    (live_sec_ones),
        .wrap    (sec_wrap)
    );

    bcd_mod_counter #(.LIMIT(MIN_LIMIT)) u_min (
        .src_clk (src_clk),
        .reset   (reset),
        .inc     (min_inc),
        .clr     (btn_rst),
        .tens    (live_min_tens),
        .ones    (live_min_ones),
        .wrap    (min_wrap)
    );

    // Mode FSM; sw_adj has priority over btn_pause, ADJ always exits to PAUSE
    always_ff @(posedge src_clk) begin
        if (reset) begin
            state   <= INIT_STATE;
            running <= (INIT_STATE == RUN);
        end else begin
            case (state)
                RUN: begin
                    if (sw_adj) begin
                        state   <= ADJ;
                        running <= 1'b0;
                    end else if (btn_pause) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (sw_adj) begin
                        state   <= ADJ;
                        running <= 1'b0;
                    end else if (btn_pause) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                ADJ: begin
                    if (!sw_adj) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end
                end
                default: begin
                    state   <= PAUSE;
                    running <= 1'b0;
                end
            endcase
        end
    end

    // Registered status outputs: rollover pulse and adjust-mode blink mask
    always_ff @(posedge src_clk) begin
        if (reset) begin
            rollover <= 1'b0;
            blank    <= 4'b0000;
        end else begin
            rollover <= in_run & min_wrap;
            blank    <= (in_adj && clk_4hz) ? blank_mask(sw_sel) : 4'b0000;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic lap_hold;
    logic leave_run;
    bcd_t lap_min_tens;
    bcd_t lap_min_ones;
    bcd_t lap_sec_tens;
    bcd_t lap_sec_ones;

    assign leave_run = in_run & (sw_adj | btn_pause);

    always_ff @(posedge src_clk) begin
        if (reset || btn_rst || leave_run) begin
            lap_hold <= 1'b0;
        end else if (in_run && btn_lap) begin
            lap_hold <= ~lap_hold;
        end
    end

    // Snapshot the live time on the press that starts a hold
    always_ff @(posedge src_clk) begin
        if (in_run && btn_lap && !lap_hold) begin
            lap_min_tens <= live_min_tens;
            lap_min_ones <= live_min_ones;
            lap_sec_tens <= live_sec_tens;
            lap_sec_ones <= live_sec_ones;
        end
    end

    assign min_tens = lap_hold ? lap_min_tens : live_min_tens;
    assign min_ones = lap_hold ? lap_min_ones : live_min_ones;
    assign sec_tens = lap_hold ? lap_sec_tens : live_sec_tens;
    assign sec_ones = lap_hold ? lap_sec_ones : live_sec_ones;
`else
    // btn_lap has no function in this build
    logic unused_lap;
    assign unused_lap = btn_lap;

    assign min_tens = live_min_tens;
    assign min_ones = live_min_ones;
    assign sec_tens = live_sec_tens;
    assign sec_ones = live_sec_ones;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl
// Self-checking bench for stopwatch_ctrl: a directed vector table, hand-written
// corner sequences and randomized stimulus against a time-in-seconds model.
module tb_stopwatch_ctrl;

    localparam int MIN_LIMIT    = 59;
    localparam int START_PAUSED = 1;
    localparam int TMAX         = (MIN_LIMIT + 1) * 60 - 1;

    logic       src_clk = 1'b0;
    logic       reset, c1, c2, c4, bp, br, bl, adj, sel;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones, blank;
    logic       running, rollover;

    int checks = 0;
    int errors = 0;

    // Reference model: time as total seconds, mode 0=run 1=pause 2=adjust
    int         m_t, m_mode, m_lap;
    bit         m_roll, m_p1, m_p2, m_hold;
    logic [3:0] m_blank;

    typedef struct {
        bit         rst, k1, k2, k4, pb, rb, aj, sl;
        int         t;
        bit         run;
        logic [3:0] blk;
        bit         roll;
    } vec_t;

    vec_t tbl[18];

    stopwatch_ctrl #(.MIN_LIMIT(MIN_LIMIT), .START_PAUSED(START_PAUSED)) dut (
        .src_clk   (src_clk),
        .reset     (reset),
        .clk_1hz   (c1),
        .clk_2hz   (c2),
        .clk_4hz   (c4),
        .btn_pause (bp),
        .btn_rst   (br),
        .btn_lap   (bl),
        .sw_adj    (adj),
        .sw_sel    (sel),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .blank     (blank),
        .running   (running),
        .rollover  (rollover)
    );

    always #5 src_clk = ~src_clk;

    function automatic logic [15:0] to_digits(input int t);
        int mm, ss;
        mm = t / 60;
        ss = t % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic logic [15:0] dut_digits();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        int nt, nmode, mm, ss;
        bit tk1, tk2;
        if (reset) begin
            m_t = 0; m_mode = (START_PAUSED != 0) ? 1 : 0;
            m_roll = 0; m_blank = 4'b0000; m_p1 = 0; m_p2 = 0; m_hold = 0;
            return;
        end
        tk1 = c1 && !m_p1;
        tk2 = c2 && !m_p2;
        m_roll  = 0;
        m_blank = (m_mode == 2 && c4) ? (sel ? 4'b0011 : 4'b1100) : 4'b0000;
        nt = m_t;
        if (br) nt = 0;
        else if (m_mode == 0 && tk1) begin
            if (m_t == TMAX) begin nt = 0; m_roll = 1; end
            else nt = m_t + 1;
        end else if (m_mode == 2 && tk2) begin
            mm = m_t / 60; ss = m_t % 60;
            if (sel) ss = (ss + 1) % 60;
            else     mm = (mm + 1) % (MIN_LIMIT + 1);
            nt = mm * 60 + ss;
        end
        if (br || (m_mode == 0 && (adj || bp))) m_hold = 0;
        else if (m_mode == 0 && bl) begin
            if (!m_hold) m_lap = m_t;
            m_hold = !m_hold;
        end
        nmode = m_mode;
        case (m_mode)
            0: if (adj) nmode = 2; else if (bp) nmode = 1;
            1: if (adj) nmode = 2; else if (bp) nmode = 0;
            default: if (!adj) nmode = 1;
        endcase
        m_t = nt; m_mode = nmode; m_p1 = c1; m_p2 = c2;
    endtask

    function automatic int shown_time();
`ifdef STOPWATCH_LAP_EN
        return m_hold ? m_lap : m_t;
`else
        return m_t;
`endif
    endfunction

    // One clock: inputs already applied, sample after the edge, compare to model
    task automatic cyc();
        @(posedge src_clk);
        #1;
        model_step();
        check("model", {dut_digits(), blank, running, rollover},
              {to_digits(shown_time()), m_blank, (m_mode == 0), m_roll});
    endtask

    task automatic tick1_n(input int n);
        for (int i = 0; i < n; i++) begin
            c1 = 1'b1; cyc();
            c1 = 1'b0; cyc();
        end
    endtask

    task automatic tick2_n(input int n);
        for (int i = 0; i < n; i++) begin
            c2 = 1'b1; cyc();
            c2 = 1'b0; cyc();
        end
    endtask

    initial begin
        reset = 1'b1; c1 = 0; c2 = 0; c4 = 0; bp = 0; br = 0; bl = 0; adj = 0; sel = 0;
        m_t = 0; m_mode = 1; m_lap = 0; m_roll = 0; m_p1 = 0; m_p2 = 0; m_hold = 0; m_blank = 0;

        //            rst k1 k2 k4 pb rb aj sl   t  run blk      roll
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 4'b0000, 0};
        tbl[1]  = '{0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 4'b0000, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 4'b0000, 0};
        tbl[3]  = '{0, 1, 0, 0, 0, 0, 0, 0,  0, 0, 4'b0000, 0};
        tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 4'b0000, 0};
        tbl[5]  = '{0, 1, 0, 1, 0, 0, 0, 0,  0, 0, 4'b0000, 0};
        tbl[6]  = '{0, 0, 0, 0, 1, 0, 0, 0,  0, 1, 4'b0000, 0};
        tbl[7]  = '{0, 1, 0, 0, 0, 0, 0, 0,  1, 1, 4'b0000, 0};
        tbl[8]  = '{0, 1, 0, 0, 0, 0, 0, 0,  1, 1, 4'b0000, 0};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 4'b0000, 0};
        tbl[10] = '{0, 1, 0, 0, 0, 1, 0, 0,  0, 1, 4'b0000, 0};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 4'b0000, 0};
        tbl[12] = '{0, 1, 0, 0, 0, 0, 0, 0,  1, 1, 4'b0000, 0};
        tbl[13] = '{0, 0, 0, 1, 0, 0, 1, 1,  1, 0, 4'b0000, 0};
        tbl[14] = '{0, 0, 0, 1, 0, 0, 1, 1,  1, 0, 4'b0011, 0};
        tbl[15] = '{0, 0, 1, 0, 0, 0, 1, 1,  2, 0, 4'b0000, 0};
        tbl[16] = '{0, 0, 0, 1, 0, 0, 1, 0,  2, 0, 4'b1100, 0};
        tbl[17] = '{0, 0, 0, 0, 0, 0, 0, 0,  2, 0, 4'b0000, 0};

        for (int i = 0; i < 18; i++) begin
            reset = tbl[i].rst; c1 = tbl[i].k1; c2 = tbl[i].k2; c4 = tbl[i].k4;
            bp = tbl[i].pb; br = tbl[i].rb; adj = tbl[i].aj; sel = tbl[i].sl;
            @(posedge src_clk);
            #1;
            model_step();
            check($sformatf("vec%0d", i), {dut_digits(), blank, running, rollover},
                  {to_digits(tbl[i].t), tbl[i].blk, tbl[i].run, tbl[i].roll});
        end
        reset = 0; c1 = 0; c2 = 0; c4 = 0; bp = 0; br = 0; adj = 0; sel = 0;

        // Reset, ticks while paused, then run 61 seconds
        reset = 1; cyc(); reset = 0;
        check("reset_digits", {dut_digits(), blank, running}, 21'h0);
        tick1_n(3);
        check("paused_hold", dut_digits(), 16'h0000);
        bp = 1; cyc(); bp = 0;
        tick1_n(61);
        check("time_0101", dut_digits(), 16'h0101);
        check("running_run", running, 1);

        // Preload 59:59 through adjust, then wrap in RUN
        adj = 1; sel = 0; cyc();
        tick2_n(58);
        sel = 1; tick2_n(58);
        check("preload_5959", dut_digits(), 16'h5959);
        adj = 0; cyc();
        bp = 1; cyc(); bp = 0;
        c1 = 1; cyc();
        check("wrap_digits", dut_digits(), 16'h0000);
        check("rollover_hi", rollover, 1);
        c1 = 0; cyc();
        check("rollover_lo", rollover, 0);

        // Wrap coinciding with btn_rst: no rollover
        adj = 1; sel = 0; cyc();
        tick2_n(59);
        sel = 1; tick2_n(59);
        adj = 0; cyc();
        bp = 1; cyc(); bp = 0;
        c1 = 1; br = 1; cyc();
        check("rst_wrap_digits", dut_digits(), 16'h0000);
        check("rst_wrap_noroll", rollover, 0);
        c1 = 0; br = 0; cyc();

        // Adjust seconds from 00:58 across the wrap, blink, ignored inputs
        adj = 1; sel = 1; cyc();
        tick2_n(58);
        tick2_n(3);
        check("adj_sec_0001", dut_digits(), 16'h0001);
        c4 = 1; cyc(); cyc();
        check("blink_on", blank, 4'b0011);
        c4 = 0; cyc(); cyc();
        check("blink_off", blank, 4'b0000);
        tick1_n(2);
        check("adj_no_count", dut_digits(), 16'h0001);
        bp = 1; cyc(); bp = 0;
        check("adj_pause_ign", running, 0);

        // Mode transitions
        adj = 0; cyc();
        check("adj_to_pause", running, 0);
        bp = 1; cyc(); bp = 0;
        check("pause_to_run", running, 1);
        adj = 1; bp = 1; cyc(); bp = 0;
        check("adj_priority", running, 0);
        adj = 0; cyc();

        // Lap behaviour
        bp = 1; cyc(); bp = 0;
        br = 1; cyc(); br = 0;
        tick1_n(10);
        bl = 1; cyc(); bl = 0;
        tick1_n(5);
`ifdef STOPWATCH_LAP_EN
        check("lap_hold", dut_digits(), 16'h0010);
`else
        check("lap_ignored", dut_digits(), 16'h0015);
`endif
        bl = 1; cyc(); bl = 0;
        check("lap_release", dut_digits(), 16'h0015);

        // Randomized stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(499) == 0);
            if ($urandom_range(3) == 0) c1 = ~c1;
            if ($urandom_range(2) == 0) c2 = ~c2;
            if ($urandom_range(1) == 0) c4 = ~c4;
            bp = ($urandom_range(15) == 0);
            br = ($urandom_range(39) == 0);
            bl = ($urandom_range(15) == 0);
            if ($urandom_range(29) == 0) adj = ~adj;
            if ($urandom_range(9) == 0) sel = ~sel;
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control FSM and time-count datapath for the stopwatch. Consumes the 1/2/4 Hz square waves from the clock divider, turns their rising edges into single-cycle enables, and sequences an MM:SS BCD counter through run, pause and adjust modes. Takes debounced button pulses and switch levels. Drives four BCD digits plus a blink mask to the seven-segment mux.

Parameters:
MIN_LIMIT, 59, highest minute value before wrap (legal 1..99).
START_PAUSED, 1, FSM state after reset: 1 = PAUSE, 0 = RUN.

Ports:
src_clk  input  1  system clock; only clock in the block
reset  input  1  synchronous, active-high reset
clk_1hz  input  1  1 Hz square wave from divider, sampled as data on src_clk
clk_2hz  input  1  2 Hz square wave, sampled as data
clk_4hz  input  1  4 Hz square wave, sampled as data
btn_pause  input  1  debounced one-cycle pulse; toggles run/pause
btn_rst  input  1  debounced one-cycle pulse; clears time to 00:00
btn_lap  input  1  debounced one-cycle pulse; lap freeze/release (used only with the optional feature)
sw_adj  input  1  level; 1 = adjust mode
sw_sel  input  1  level; adjust field select: 0 = minutes, 1 = seconds
min_tens  output  4  BCD minutes tens
min_ones  output  4  BCD minutes ones
sec_tens  output  4  BCD seconds tens
sec_ones  output  4  BCD seconds ones
blank  output  4  per-digit blank request {min_tens, min_ones, sec_tens, sec_ones}
running  output  1  1 while FSM is in RUN
rollover  output  1  one-cycle pulse when the time wraps from MIN_LIMIT:59 to 00:00 in RUN

Behaviour:
- Reset is synchronous and active-high, sampled on the rising edge of src_clk. On reset:
  - all digits = 0 and blank = 0000;
  - rollover = 0;
  - edge-detect registers = 0;
  - state = PAUSE if START_PAUSED = 1, else RUN;
  - running reflects that state.
  Reset mid-count discards the current time. A tick rising edge on the first cycle after reset is detected normally.
- Tick generation: tick_N = clk_Nhz & ~clk_Nhz_d, where clk_Nhz_d is the previous-cycle sample. Each tick is exactly one src_clk cycle wide, once per input period. All outputs are registered and update on the clock edge that ends the tick cycle.
- FSM states: RUN, PAUSE, ADJ.
  - RUN: btn_pause -> PAUSE; sw_adj=1 -> ADJ.
  - PAUSE: btn_pause -> RUN; sw_adj=1 -> ADJ.
  - ADJ: btn_pause is ignored; sw_adj=0 -> PAUSE (always PAUSE, never RUN).
  - sw_adj has priority over btn_pause in the same cycle.
- Counting in RUN, on tick_1:
  - seconds increment BCD 00..59;
  - 59 -> 00 carries into minutes;
  - minutes increment 00..MIN_LIMIT;
  - at MIN_LIMIT:59 both fields wrap to 00:00 and rollover pulses for one cycle.
- PAUSE: time holds.
- ADJ: time does not count. On tick_2 the field selected by sw_sel increments by one with wrap (seconds 59->00, minutes MIN_LIMIT->00), with no carry between fields. The unselected field holds.
- Blink: in ADJ, the two digits of the selected field have blank = 1 while clk_4hz is high (registered). All other digits, and all digits outside ADJ, have blank = 0.
- btn_rst:
  - clears time to 00:00 in any state on the next edge;
  - state is unchanged;
  - btn_rst wins over a tick_1 or tick_2 increment in the same cycle;
  - a btn_rst coincident with a wrap suppresses rollover.
- Digits never leave the legal BCD range. Ones digits 0..9. Seconds tens 0..5. Minutes tens 0..floor(MIN_LIMIT/10).

Optional Feature:
STOPWATCH_LAP_EN
- Defined:
  - btn_lap in RUN toggles a lap_hold flag;
  - while lap_hold = 1, the digit outputs show the value latched at the btn_lap cycle while internal counting continues;
  - a second btn_lap releases the hold, and the outputs show live time on the next edge;
  - btn_rst, a transition to PAUSE or ADJ, and reset all clear lap_hold;
  - btn_lap is ignored in PAUSE and ADJ.
- Undefined: btn_lap is ignored, the outputs always show live time, and no lap registers are synthesized.

Decomposition:
- Package stopwatch_pkg:
  - state enum {RUN, PAUSE, ADJ};
  - bcd_t (4-bit) typedef;
  - SEC_LIMIT = 59;
  - digit-index constants for the blank vector.
- Sub-module bcd_mod_counter: two-digit BCD counter.
  - Parameter: LIMIT.
  - Inputs: inc, clr, reset.
  - Outputs: tens, ones, wrap (combinational: inc & at-limit).
  - Instantiated twice: seconds with LIMIT = 59, minutes with LIMIT = MIN_LIMIT.
- The FSM, edge detection and blink logic stay in stopwatch_ctrl.

Test Plan:
1. Reset with START_PAUSED=1, then 3 clk_1hz rising edges -> digits stay 00:00; running=0; blank=0000.
2. btn_pause, then 61 clk_1hz rising edges -> 01:01. Each digit update lands on the edge after the rising edge is sampled. running=1.
3. Preload 59:59 in RUN (MIN_LIMIT=59), then 1 tick -> 00:00 and rollover high for exactly 1 cycle. With btn_rst in the same cycle -> 00:00 and rollover=0.
4. sw_adj=1, sw_sel=1, time 00:58, then 3 clk_2hz edges -> 00:01 with minutes unchanged. blank=0011 while clk_4hz high, 0000 while low. clk_1hz edges have no effect. btn_pause ignored.
5. sw_adj falls -> PAUSE (running=0). btn_pause -> RUN. sw_adj and btn_pause asserted in the same cycle -> ADJ.
6. With STOPWATCH_LAP_EN: RUN at 00:10, btn_lap, then 5 ticks -> outputs hold 00:10. Second btn_lap -> outputs show 00:15. Without the macro, btn_lap has no effect.
